// File: rtl/spi_slave_rx_deser_pkg.sv
// rtl/spi_slave_rx_deser_pkg.sv - shared types and defaults for the SPI slave receive path
package spi_slave_rx_deser_pkg;

    localparam int SPI_WORD_W = 8;

    typedef enum logic {
        SPI_ST_IDLE   = 1'b0,
        SPI_ST_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_slave_rx_deser_if.sv
// rtl/spi_slave_rx_deser_if.sv - received-word stream with start-of-frame tag
interface spi_slave_rx_deser_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] o_data;
    logic              o_sof;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output o_data,
        output o_sof,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_sof,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/spi_slave_rx_deser_sync_fifo.sv
// rtl/spi_slave_rx_deser_sync_fifo.sv - show-ahead synchronous FIFO, shared by RX and future TX paths
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_last;
    logic             w_rd;
    logic             w_wr;

    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign w_rd  = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is allowed then.
    assign w_wr  = wr_en & (~full | w_rd);

    // Once drained, keep showing the last word popped rather than a stale slot.
    assign dout  = empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/spi_slave_rx_deser.sv
// rtl/spi_slave_rx_deser.sv - SPI mode 0 slave receive deserializer with output FIFO
module spi_slave_rx_deser
    import spi_slave_rx_deser_pkg::*;
#(
    parameter int DATA_W     = SPI_WORD_W,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_spi_clk,
    input  logic                  i_spi_mosi,
    input  logic                  i_spi_cs_n,
    spi_slave_rx_deser_if.master  o_strm,
    output logic                  o_busy,
    output logic                  o_frame_err,
    output logic                  o_overflow
);
    localparam int              CW       = $clog2(DATA_W);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);

    spi_state_t        r_state;
    spi_state_t        w_state_nxt;
    logic              r_clk_d;
    logic              r_cs_n_d;
    logic              r_hist_vld;
    logic [CW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_sof_pend;
    logic              r_frame_err;
    logic              r_overflow;

    logic              w_sclk_rise;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_bit_en;
    logic              w_word_done;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W:0]   w_dout;

    // Edges are only trusted once the history registers hold a real sample, so a CS
    // already low at reset release is not mistaken for a falling edge.
    assign w_sclk_rise = i_spi_clk & ~r_clk_d;
    assign w_cs_fall   = r_hist_vld & ~i_spi_cs_n & r_cs_n_d;
    assign w_cs_rise   = r_hist_vld & i_spi_cs_n & ~r_cs_n_d;

    assign w_bit_en    = (r_state == SPI_ST_ACTIVE) & w_sclk_rise & ~w_cs_rise;
    assign w_word_done = w_bit_en & (r_bit_cnt == LAST_BIT);
    assign w_shift_nxt = MSB_FIRST ? {r_shift[DATA_W-2:0], i_spi_mosi}
                                   : {i_spi_mosi, r_shift[DATA_W-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SPI_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SPI_ST_IDLE:   if (w_cs_fall) w_state_nxt = SPI_ST_ACTIVE;
            SPI_ST_ACTIVE: if (w_cs_rise) w_state_nxt = SPI_ST_IDLE;
            default:       w_state_nxt = SPI_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_d     <= 1'b0;
            r_cs_n_d    <= 1'b1;
            r_hist_vld  <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_sof_pend  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_clk_d     <= i_spi_clk;
            r_cs_n_d    <= i_spi_cs_n;
            r_hist_vld  <= 1'b1;
            r_frame_err <= (r_state == SPI_ST_ACTIVE) & w_cs_rise & (r_bit_cnt != '0);
            r_overflow  <= w_word_done & w_full & ~w_pop;
            if ((r_state == SPI_ST_IDLE) && w_cs_fall) begin
                r_bit_cnt  <= '0;
                r_sof_pend <= 1'b1;
            end else if ((r_state == SPI_ST_ACTIVE) && w_cs_rise) begin
                r_bit_cnt <= '0;
            end else if (w_bit_en) begin
                r_shift <= w_shift_nxt;
                if (w_word_done) begin
                    r_bit_cnt  <= '0;
                    r_sof_pend <= 1'b0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign w_pop = ~w_empty & o_strm.i_ready;

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .wr_en (w_word_done),
        .din   ({r_sof_pend, w_shift_nxt}),
        .rd_en (o_strm.i_ready),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign o_strm.o_data  = w_dout[DATA_W-1:0];
    assign o_strm.o_sof   = w_dout[DATA_W];
    assign o_strm.o_valid = ~w_empty;
    assign o_busy         = (r_state == SPI_ST_ACTIVE);
    assign o_frame_err    = r_frame_err;
    assign o_overflow     = r_overflow;
endmodule
